// File: rtl/filtd_chan_sched.sv
// filtd_chan_sched: round-robin scheduler sharing one FILTD datapath across NCH channels,
// holding per-channel YU state and limiting each FILTD result to 544..5120.
module filtd_chan_sched #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req,
    input  logic [12*NCH-1:0] wi_bus,
    output logic [NCH-1:0]    ack,
    output logic [12:0]       yu_out,
    output logic [CW-1:0]     ch_out,
    output logic              yu_valid,
    output logic              busy,
    output logic [11:0]       f_wi,
    output logic [12:0]       f_y,
    input  logic [12:0]       f_yut
);
    localparam logic [12:0] YMIN = 13'd544;
    localparam logic [12:0] YMAX = 13'd5120;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t        state_q, state_d;
    logic [12:0]   ystate_q [NCH];
    logic [CW-1:0] rr_q, g_q, pick, cand;
    logic [11:0]   f_wi_q;
    logic [12:0]   f_y_q, yu_out_q, yu_lim;
    logic [CW-1:0] ch_out_q;
    logic          yu_valid_q, hit, grant, wb;
    logic [NCH-1:0] ack_q;
    logic [11:0]   wi_arr [NCH];

    always_comb begin
        for (int i = 0; i < NCH; i++) wi_arr[i] = wi_bus[12*i +: 12];
    end

    // First requester at or after the pointer, wrapping modulo NCH.
    always_comb begin
        pick = '0;
        cand = '0;
        hit  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            cand = CW'((int'(rr_q) + i) % NCH);
            if (!hit && req[cand]) begin
                hit  = 1'b1;
                pick = cand;
            end
        end
    end

    assign yu_lim = (f_yut < YMIN) ? YMIN : (f_yut > YMAX) ? YMAX : f_yut;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE)  ? (hit ? ISSUE : IDLE) :
                  (state_q == ISSUE) ? DONE : IDLE;
    end

    always_comb begin
        busy  = (state_q == ISSUE) || (state_q == DONE);
        grant = (state_q == IDLE) && hit;
        wb    = (state_q == ISSUE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) ystate_q[i] <= YMIN;
            rr_q       <= '0;
            g_q        <= '0;
            f_wi_q     <= '0;
            f_y_q      <= '0;
            yu_out_q   <= '0;
            ch_out_q   <= '0;
            yu_valid_q <= 1'b0;
            ack_q      <= '0;
        end else begin
            ack_q      <= '0;
            yu_valid_q <= 1'b0;
            if (grant) begin
                g_q    <= pick;
                f_wi_q <= wi_arr[pick];
                f_y_q  <= ystate_q[pick];
            end
            if (wb) begin
                ystate_q[g_q] <= yu_lim;
                yu_out_q      <= yu_lim;
                ch_out_q      <= g_q;
                yu_valid_q    <= 1'b1;
                ack_q         <= NCH'(1) << g_q;
                rr_q          <= (int'(g_q) == NCH - 1) ? '0 : g_q + 1'b1;
            end
        end
    end

    assign ack      = ack_q;
    assign yu_out   = yu_out_q;
    assign ch_out   = ch_out_q;
    assign yu_valid = yu_valid_q;
    assign f_wi     = f_wi_q;
    assign f_y      = f_y_q;
endmodule

// File: tb/tb_filtd_chan_sched.sv
// tb_filtd_chan_sched: directed table, corner sequences and randomized traffic against
// a transaction-level model of the scheduler with an arithmetic FILTD stand-in.
module tb_filtd_chan_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [47:0] wi_bus;
    logic [3:0]  ack;
    logic [12:0] yu_out;
    logic [1:0]  ch_out;
    logic        yu_valid, busy;
    logic [11:0] f_wi;
    logic [12:0] f_y, f_yut;

    int n_cmp = 0;
    int n_err = 0;
    int yref [4];
    int rr_m;

    filtd_chan_sched #(.NCH(4), .CW(2)) dut (
        .clk(clk), .reset(reset), .req(req), .wi_bus(wi_bus), .ack(ack),
        .yu_out(yu_out), .ch_out(ch_out), .yu_valid(yu_valid), .busy(busy),
        .f_wi(f_wi), .f_y(f_y), .f_yut(f_yut)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] filtd(input logic [11:0] wi, input logic [12:0] y);
        int dif, difsx;
        dif   = ((int'(wi) << 5) + 131072 - int'(y)) % 131072;
        difsx = (dif >> 5) + ((dif >= 65536) ? 4096 : 0);
        return 13'((int'(y) + difsx) % 8192);
    endfunction

    function automatic int limb(input int v);
        return v < 544 ? 544 : v > 5120 ? 5120 : v;
    endfunction

    assign f_yut = filtd(f_wi, f_y);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) yref[i] = 544;
        rr_m = 0;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ack"}, int'(ack), 0);
        chk({nm, "_valid"}, int'(yu_valid), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_yu"}, int'(yu_out), 0);
        chk({nm, "_ch"}, int'(ch_out), 0);
        chk({nm, "_fwi"}, int'(f_wi), 0);
        chk({nm, "_fy"}, int'(f_y), 0);
    endtask

    // Single-channel update with cycle-exact checks of the ISSUE and DONE phases.
    task automatic do_update(input int ch, input logic [11:0] wi, input int fy, input int yu);
        wi_bus[ch*12 +: 12] = wi;
        req = 4'(1 << ch);
        tick();
        chk("issue_busy", int'(busy), 1);
        chk("issue_ack", int'(ack), 0);
        chk("issue_fwi", int'(f_wi), int'(wi));
        chk("issue_fy", int'(f_y), fy);
        tick();
        chk("done_ack", int'(ack), 1 << ch);
        chk("done_valid", int'(yu_valid), 1);
        chk("done_yu", int'(yu_out), yu);
        chk("done_ch", int'(ch_out), ch);
        chk("done_busy", int'(busy), 1);
        req = 4'b0;
        tick();
        chk("idle_ack", int'(ack), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_hold_yu", int'(yu_out), yu);
        yref[ch] = yu;
        rr_m = (ch + 1) % 4;
    endtask

    typedef struct {
        int          ch;
        logic [11:0] wi;
        int          fy;
        int          yu;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pending, newr, w, ch, eyu, k;
        logic [11:0] wiv [4];
        vecs[0] = '{0, 12'd1000, 544, 1527};
        vecs[1] = '{0, 12'd1000, 1527, 2479};
        vecs[2] = '{1, 12'd0, 544, 544};
        vecs[3] = '{2, 12'd2047, 544, 2574};
        vecs[4] = '{2, 12'd2047, 2574, 4540};
        vecs[5] = '{2, 12'd2047, 4540, 5120};
        vecs[6] = '{2, 12'd2047, 5120, 5120};
        reset = 1'b1;
        req = 4'b0;
        wi_bus = '0;
        model_reset();
        tick();
        tick();
        check_zero("reset");
        reset = 1'b0;
        tick();
        check_zero("post_reset");

        foreach (vecs[i]) do_update(vecs[i].ch, vecs[i].wi, vecs[i].fy, vecs[i].yu);
        do_update(3, 12'd0, 544, 544);

        // All channels requesting with pointer at 0: grants 0,1,2,3,0 every 3 clocks.
        for (int i = 0; i < 4; i++) wiv[i] = 12'($urandom_range(0, 4095));
        for (int i = 0; i < 4; i++) wi_bus[i*12 +: 12] = wiv[i];
        req = 4'b1111;
        k = 0;
        for (int t = 1; t <= 15; t++) begin
            tick();
            if (t % 3 == 2) begin
                ch = k % 4;
                eyu = limb(int'(filtd(wiv[ch], 13'(yref[ch]))));
                chk("rr_ack", int'(ack), 1 << ch);
                chk("rr_yu", int'(yu_out), eyu);
                yref[ch] = eyu;
                k++;
            end else begin
                chk("rr_noack", int'(ack), 0);
            end
        end
        req = 4'b0;
        tick();
        rr_m = 1;

        // Reset while channel 3 is in ISSUE abandons the update.
        wi_bus[36 +: 12] = 12'd2000;
        req = 4'b1000;
        tick();
        chk("abort_issue_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        check_zero("abort");
        reset = 1'b0;
        req = 4'b0;
        model_reset();
        tick();
        do_update(3, 12'd0, 544, 544);

        // Randomized traffic against the transaction-level model.
        pending = 0;
        for (int n = 0; n < 200; n++) begin
            newr = int'($urandom_range(0, 15));
            if ((pending | newr) == 0) newr = 1 << $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) begin
                if (newr[i] && !pending[i]) begin
                    wiv[i] = 12'($urandom_range(0, 4095));
                    wi_bus[i*12 +: 12] = wiv[i];
                end
            end
            pending |= newr;
            req = 4'(pending);
            ch = -1;
            for (int i = 0; i < 4; i++) begin
                if (ch < 0 && pending[(rr_m + i) % 4]) ch = (rr_m + i) % 4;
            end
            w = 0;
            do begin
                tick();
                w++;
            end while (!yu_valid && w < 8);
            chk("rand_timeout", int'(yu_valid), 1);
            if (yu_valid) begin
                eyu = limb(int'(filtd(wiv[ch], 13'(yref[ch]))));
                chk("rand_ack", int'(ack), 1 << ch);
                chk("rand_ch", int'(ch_out), ch);
                chk("rand_yu", int'(yu_out), eyu);
                yref[ch] = eyu;
                rr_m = (ch + 1) % 4;
                pending &= ~(1 << ch);
                req = 4'(pending);
                tick();
                chk("rand_ack_clear", int'(ack), 0);
            end
        end
        req = 4'b0;
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
